// File: rtl/adc_sample_averager.sv
// adc_sample_averager
//   Turns the MCP3202 SPI master's level-style DATA_VALID flag into single
//   sample events. It boxcar-averages 2^AVG_LOG2 consecutive samples with
//   rounding and presents each result on a valid/ready port.
//
//   Optional build macro: ADC_AVG_SIGNED_OUT_EN
//     defined   -> o_SAMPLE is two's complement centred on mid-scale
//     undefined -> o_SAMPLE is unsigned offset binary
//
// Ports
//   clk           system clock (same domain as the SPI master)
//   reset         synchronous, active-high reset
//   EN            block enable; EN=0 returns to IDLE and drops any partial sum
//   i_DATA        ADC word, stable while i_DATA_VALID is high
//   i_DATA_VALID  level flag, high for many cycles per sample
//   o_SAMPLE      averaged sample
//   o_VALID       o_SAMPLE holds an unconsumed result
//   i_READY       consumer accepts o_SAMPLE when o_VALID && i_READY
//   o_OVERRUN     one-cycle pulse when an unconsumed result is overwritten
//   o_BUSY        a partial average is being accumulated (count != 0)
module adc_sample_averager #(
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned DATA_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EN,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic              i_DATA_VALID,
  output logic [DATA_W-1:0] o_SAMPLE,
  output logic              o_VALID,
  input  logic              i_READY,
  output logic              o_OVERRUN,
  output logic              o_BUSY
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);
  // Half an LSB of the output for round-half-up; zero in pass-through.
  localparam logic [ACC_W-1:0] RND = ACC_W'((2 ** AVG_LOG2) / 2);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACCUM
  } state_t;

  state_t            state;
  logic              dv_q;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;

  logic              strobe;
  logic              last;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] out_word;

  always_comb begin
    strobe = i_DATA_VALID & ~dv_q & (state == ACCUM);
    // A completing strobe that coincides with EN=0 is discarded along with
    // the partial sum, so the result load is also gated by EN.
    last   = strobe & EN & (count == CNT_LAST);
    // Cannot overflow: N*(2^DATA_W-1) + N/2 < 2^(DATA_W+AVG_LOG2) for all N.
    sum    = acc + ACC_W'(i_DATA) + RND;
    result = DATA_W'(sum >> AVG_LOG2);
`ifdef ADC_AVG_SIGNED_OUT_EN
    out_word = {~result[DATA_W-1], result[DATA_W-2:0]};
`else
    out_word = result;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dv_q      <= 1'b0;
      acc       <= '0;
      count     <= '0;
      o_SAMPLE  <= '0;
      o_VALID   <= 1'b0;
      o_OVERRUN <= 1'b0;
      o_BUSY    <= 1'b0;
    end else begin
      dv_q <= i_DATA_VALID;

      // Output port: a new result always wins over a transfer in the same
      // cycle; overrun only when the old result was neither taken nor read.
      if (last) begin
        o_SAMPLE  <= out_word;
        o_VALID   <= 1'b1;
        o_OVERRUN <= o_VALID & ~i_READY;
      end else begin
        o_OVERRUN <= 1'b0;
        if (o_VALID && i_READY) begin
          o_VALID <= 1'b0;
        end
      end

      if (!EN) begin
        state  <= IDLE;
        acc    <= '0;
        count  <= '0;
        o_BUSY <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= ARM;
            acc    <= '0;
            count  <= '0;
            o_BUSY <= 1'b0;
          end
          // A flag already high at enable time belongs to a sample that may
          // have started before we were listening; wait for it to drop.
          ARM: begin
            if (!i_DATA_VALID) begin
              state <= ACCUM;
            end
          end
          ACCUM: begin
            if (strobe) begin
              if (last) begin
                acc    <= '0;
                count  <= '0;
                o_BUSY <= 1'b0;
              end else begin
                acc    <= acc + ACC_W'(i_DATA);
                count  <= count + CNT_W'(1);
                o_BUSY <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager. Three instances with AVG_LOG2 = 0,
// 1 and 2 are exercised one after another; index k of each signal array
// belongs to the instance with AVG_LOG2 = k.
module tb_adc_sample_averager;

  logic        clk = 1'b0;
  logic        reset;
  logic        en   [3];
  logic        dv   [3];
  logic        rdy  [3];
  logic [11:0] d    [3];
  logic [11:0] s    [3];
  logic        v    [3];
  logic        ov   [3];
  logic        b    [3];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #4 clk = ~clk;

  adc_sample_averager #(.AVG_LOG2(0), .DATA_W(12)) u_avg0 (
    .clk(clk), .reset(reset), .EN(en[0]), .i_DATA(d[0]), .i_DATA_VALID(dv[0]),
    .o_SAMPLE(s[0]), .o_VALID(v[0]), .i_READY(rdy[0]), .o_OVERRUN(ov[0]), .o_BUSY(b[0])
  );
  adc_sample_averager #(.AVG_LOG2(1), .DATA_W(12)) u_avg1 (
    .clk(clk), .reset(reset), .EN(en[1]), .i_DATA(d[1]), .i_DATA_VALID(dv[1]),
    .o_SAMPLE(s[1]), .o_VALID(v[1]), .i_READY(rdy[1]), .o_OVERRUN(ov[1]), .o_BUSY(b[1])
  );
  adc_sample_averager #(.AVG_LOG2(2), .DATA_W(12)) u_avg2 (
    .clk(clk), .reset(reset), .EN(en[2]), .i_DATA(d[2]), .i_DATA_VALID(dv[2]),
    .o_SAMPLE(s[2]), .o_VALID(v[2]), .i_READY(rdy[2]), .o_OVERRUN(ov[2]), .o_BUSY(b[2])
  );

  // Expected o_SAMPLE for a given unsigned average in the current build.
  function automatic logic [11:0] to_out(input logic [11:0] x);
`ifdef ADC_AVG_SIGNED_OUT_EN
    return {~x[11], x[10:0]};
`else
    return x;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise DV with a new word; returns just after the strobe edge.
  task automatic rise(input int unsigned k, input logic [11:0] val);
    d[k]  = val;
    dv[k] = 1'b1;
    tick();
  endtask

  // Hold DV a few more cycles, then drop it for one cycle.
  task automatic fall(input int unsigned k);
    repeat (3) tick();
    dv[k] = 1'b0;
    tick();
  endtask

  int unsigned nres;
  logic [11:0] cap;
  logic [11:0] sgn_in  [3] = '{12'h800, 12'h000, 12'hFFF};
`ifdef ADC_AVG_SIGNED_OUT_EN
  logic [11:0] sgn_exp [3] = '{12'h000, 12'h800, 12'h7FF};
`else
  logic [11:0] sgn_exp [3] = '{12'h800, 12'h000, 12'hFFF};
`endif

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; dv[i] = 1'b0; rdy[i] = 1'b0; d[i] = '0;
    end
    repeat (3) tick();
    chk("rst_sample", 32'(s[2]), 32'h0);
    chk("rst_valid", 32'(v[2]), 32'h0);
    chk("rst_overrun", 32'(ov[2]), 32'h0);
    chk("rst_busy", 32'(b[2]), 32'h0);
    reset = 1'b0;

    // AVG_LOG2=2, ready high: 100..103 -> 102
    rdy[2] = 1'b1;
    en[2]  = 1'b1;
    tick(); tick();
    rise(2, 12'd100); chk("avg4_busy_s1", 32'(b[2]), 32'h1); fall(2);
    rise(2, 12'd101); chk("avg4_busy_s2", 32'(b[2]), 32'h1); fall(2);
    rise(2, 12'd102); chk("avg4_busy_s3", 32'(b[2]), 32'h1); fall(2);
    chk("avg4_pre_valid", 32'(v[2]), 32'h0);
    rise(2, 12'd103);
    chk("avg4_valid", 32'(v[2]), 32'h1);
    chk("avg4_sample", 32'(s[2]), 32'(to_out(12'd102)));
    chk("avg4_busy_done", 32'(b[2]), 32'h0);
    fall(2);
    chk("avg4_taken", 32'(v[2]), 32'h0);

    // AVG_LOG2=0: one long DV pulse gives exactly one result
    rdy[0] = 1'b1;
    en[0]  = 1'b1;
    tick(); tick();
    d[0]  = 12'hABC;
    dv[0] = 1'b1;
    nres  = 0;
    cap   = '0;
    repeat (300) begin
      tick();
      if (v[0]) begin
        nres++;
        cap = s[0];
      end
    end
    chk("pass_count", nres, 32'd1);
    chk("pass_sample", 32'(cap), 32'(to_out(12'hABC)));
    dv[0] = 1'b0;
    tick();

    // Mid-scale and extreme codes through the output format
    for (int i = 0; i < 3; i++) begin
      rise(0, sgn_in[i]);
      chk("fmt_valid", 32'(v[0]), 32'h1);
      chk("fmt_sample", 32'(s[0]), 32'(sgn_exp[i]));
      fall(0);
    end

    // AVG_LOG2=1: enable while DV already high with 0x7FF -> ignored
    rdy[1] = 1'b0;
    d[1]   = 12'h7FF;
    dv[1]  = 1'b1;
    tick();
    en[1] = 1'b1;
    repeat (4) tick();
    chk("arm_busy", 32'(b[1]), 32'h0);
    chk("arm_valid", 32'(v[1]), 32'h0);
    dv[1] = 1'b0;
    tick();
    rise(1, 12'd10); chk("arm_first_counted", 32'(b[1]), 32'h1); fall(1);
    rise(1, 12'd20);
    chk("ovr_first_valid", 32'(v[1]), 32'h1);
    chk("ovr_first_sample", 32'(s[1]), 32'(to_out(12'd15)));
    chk("ovr_first_no_ovr", 32'(ov[1]), 32'h0);
    fall(1);
    rise(1, 12'd30); fall(1);
    chk("ovr_hold_sample", 32'(s[1]), 32'(to_out(12'd15)));
    rise(1, 12'd40);
    chk("ovr_second_sample", 32'(s[1]), 32'(to_out(12'd35)));
    chk("ovr_second_valid", 32'(v[1]), 32'h1);
    chk("ovr_pulse", 32'(ov[1]), 32'h1);
    tick();
    chk("ovr_pulse_end", 32'(ov[1]), 32'h0);
    chk("ovr_still_valid", 32'(v[1]), 32'h1);
    dv[1]  = 1'b0;
    rdy[1] = 1'b1;
    tick();
    chk("ovr_taken", 32'(v[1]), 32'h0);

    // AVG_LOG2=2: partial sum dropped by EN=0
    rise(2, 12'd50); fall(2);
    rise(2, 12'd60); fall(2);
    chk("abort_busy_before", 32'(b[2]), 32'h1);
    en[2] = 1'b0;
    repeat (5) tick();
    chk("abort_busy_idle", 32'(b[2]), 32'h0);
    en[2] = 1'b1;
    tick(); tick();
    rise(2, 12'd4); fall(2);
    rise(2, 12'd4); chk("abort_no_early", 32'(v[2]), 32'h0); fall(2);
    rise(2, 12'd4); fall(2);
    rise(2, 12'd4);
    chk("abort_valid", 32'(v[2]), 32'h1);
    chk("abort_sample", 32'(s[2]), 32'(to_out(12'd4)));
    fall(2);

    // Reset mid-accumulation
    rise(2, 12'd7); fall(2);
    chk("midrst_busy_before", 32'(b[2]), 32'h1);
    reset = 1'b1;
    tick();
    chk("midrst_busy", 32'(b[2]), 32'h0);
    chk("midrst_valid", 32'(v[2]), 32'h0);
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
